// File: rtl/serial_adder_pkg.sv
// Shared definitions for the 2-bit serial adder block set.
// Holds the default widths and the sum collector FSM state type.
package serial_adder_pkg;

  localparam int SUM_W_DEF  = 3;
  localparam int OPND_W_DEF = 2;

  typedef enum logic {
    COL_IDLE,
    COL_SHIFT
  } col_state_t;

endpackage

// File: rtl/serial_sum_collector_fifo.sv
// sync_fifo_fwft: registered first-word-fall-through FIFO.
// Head word is read straight from storage; push may land when full only alongside a pop.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_sum_collector.sv
// Reassembles LSB-first serial sum frames into words and buffers them in a FIFO.
// SERIAL_SUM_COLLECTOR_STATS_EN adds saturating ok/error/drop counters.
module serial_sum_collector
  import serial_adder_pkg::*;
#(
  parameter int SUM_W      = SUM_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_en_i,
  output logic [SUM_W-1:0] sum_o,
  output logic             sum_valid_o,
  input  logic             sum_ready_i,
  output logic             overflow_o,
`ifdef SERIAL_SUM_COLLECTOR_STATS_EN
  output logic [15:0]      frames_ok_o,
  output logic [7:0]       frames_err_o,
  output logic [7:0]       drops_o,
`endif
  output logic             frame_err_o
);

  localparam int CW = $clog2(SUM_W);

  col_state_t       state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [SUM_W-1:0] shreg, shreg_d;
  logic [SUM_W-1:0] word;
  logic             push;
  logic             err_d;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic             unused_count;

  assign word = {ser_in, shreg[SUM_W-2:0]};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    shreg_d = shreg;
    push    = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      COL_IDLE: begin
        if (ser_en_i) begin
          shreg_d    = '0;
          shreg_d[0] = ser_in;
          cnt_d      = CW'(1);
          state_d    = COL_SHIFT;
        end
      end
      COL_SHIFT: begin
        if (ser_en_i) begin
          err_d      = 1'b1;
          shreg_d    = '0;
          shreg_d[0] = ser_in;
          cnt_d      = CW'(1);
        end else if (cnt == CW'(SUM_W-1)) begin
          push    = 1'b1;
          cnt_d   = '0;
          state_d = COL_IDLE;
        end else begin
          shreg_d[cnt] = ser_in;
          cnt_d        = cnt + 1'b1;
        end
      end
      default: state_d = COL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COL_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      shreg       <= shreg_d;
      frame_err_o <= err_d;
      if (drop) overflow_o <= 1'b1;
    end
  end

  assign sum_valid_o  = !fifo_empty;
  assign pop          = sum_valid_o && sum_ready_i;
  assign drop         = push && fifo_full && !pop;
  assign unused_count = ^fifo_count;

  sync_fifo_fwft #(
    .WIDTH (SUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (word),
    .pop   (pop),
    .dout  (sum_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef SERIAL_SUM_COLLECTOR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_ok_o  <= '0;
      frames_err_o <= '0;
      drops_o      <= '0;
    end else begin
      if (push && !drop && frames_ok_o != '1)
        frames_ok_o <= frames_ok_o + 1'b1;
      if (err_d && frames_err_o != '1)
        frames_err_o <= frames_err_o + 1'b1;
      if (drop && drops_o != '1)
        drops_o <= drops_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_sum_collector.sv
// Randomized and directed bench for serial_sum_collector against a queue-based model.
// Stats checks are compiled in with SERIAL_SUM_COLLECTOR_STATS_EN.
module tb_serial_sum_collector;

  localparam int W = 3;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ser_in;
  logic         ser_en_i;
  logic [W-1:0] sum_o;
  logic         sum_valid_o;
  logic         sum_ready_i;
  logic         overflow_o;
  logic         frame_err_o;
`ifdef SERIAL_SUM_COLLECTOR_STATS_EN
  logic [15:0]  frames_ok_o;
  logic [7:0]   frames_err_o;
  logic [7:0]   drops_o;
`endif

  always #5 clk = ~clk;

  serial_sum_collector #(
    .SUM_W      (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ser_in       (ser_in),
    .ser_en_i     (ser_en_i),
    .sum_o        (sum_o),
    .sum_valid_o  (sum_valid_o),
    .sum_ready_i  (sum_ready_i),
    .overflow_o   (overflow_o),
`ifdef SERIAL_SUM_COLLECTOR_STATS_EN
    .frames_ok_o  (frames_ok_o),
    .frames_err_o (frames_err_o),
    .drops_o      (drops_o),
`endif
    .frame_err_o  (frame_err_o)
  );

  int total = 0;
  int bad   = 0;

  bit           m_bits[$];
  logic [W-1:0] m_q[$];
  bit           m_ovf;
  bit           m_err;
  int           m_ok;
  int           m_errs;
  int           m_drops;

  task automatic check(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("valid", int'(sum_valid_o), int'(m_q.size() > 0));
    if (m_q.size() > 0) check("sum", int'(sum_o), int'(m_q[0]));
    check("overflow", int'(overflow_o), int'(m_ovf));
    check("frame_err", int'(frame_err_o), int'(m_err));
`ifdef SERIAL_SUM_COLLECTOR_STATS_EN
    check("frames_ok", int'(frames_ok_o), m_ok);
    check("frames_err", int'(frames_err_o), m_errs);
    check("drops", int'(drops_o), m_drops);
`endif
  endtask

  task automatic model_step(bit r, bit en, bit b, bit rdy);
    bit           pop;
    bit           have;
    bit           room;
    logic [W-1:0] w;
    if (r) begin
      m_bits.delete();
      m_q.delete();
      m_ovf   = 0;
      m_err   = 0;
      m_ok    = 0;
      m_errs  = 0;
      m_drops = 0;
      return;
    end
    pop   = (m_q.size() > 0) && rdy;
    have  = 0;
    w     = '0;
    m_err = 0;
    if (en) begin
      if (m_bits.size() > 0) begin
        m_err = 1;
        if (m_errs < 255) m_errs++;
      end
      m_bits.delete();
      m_bits.push_back(b);
    end else if (m_bits.size() > 0) begin
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        for (int k = 0; k < W; k++) w[k] = m_bits[k];
        have = 1;
        m_bits.delete();
      end
    end
    room = (m_q.size() < D) || pop;
    if (pop) void'(m_q.pop_front());
    if (have) begin
      if (room) begin
        m_q.push_back(w);
        if (m_ok < 65535) m_ok++;
      end else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  task automatic cycle(bit r, bit en, bit b, bit rdy);
    @(negedge clk);
    compare_all();
    rst         = r;
    ser_en_i    = en;
    ser_in      = b;
    sum_ready_i = rdy;
    model_step(r, en, b, rdy);
  endtask

  task automatic send_frame(int val, bit rdy);
    for (int k = 0; k < W; k++)
      cycle(1'b0, k == 0, val[k], rdy);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    rst         = 1'b1;
    ser_en_i    = 1'b0;
    ser_in      = 1'b0;
    sum_ready_i = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    send_frame(5, 1'b1);
    idle(3, 1'b1);

    send_frame(0, 1'b0);
    send_frame(7, 1'b0);
    send_frame(4, 1'b0);
    send_frame(6, 1'b0);
    idle(3, 1'b0);
    send_frame(3, 1'b0);
    idle(2, 1'b0);
    check("ovf_sticky", int'(overflow_o), 1);
    idle(6, 1'b1);

    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(2, 1'b1);
    idle(3, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 3) == 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 2) != 0);
    end
    idle(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
